sorter_frame_loader: RTL and testbench
======================================

# sorter_frame_loader

Sequential front/back-end for the combinational 8-bit perceptron sorter. It assembles a bit-serial input stream into 8-bit frames and drives them onto the sorter's `inp` bus. After a fixed settle time it captures the sorter's `out` bus and checks it against the ideal sorted (thermometer) result. The captured result is presented downstream on a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 8: frame width; must match the sorter (only 8 is supported).
- `SETTLE_CYCLES`, 2: cycles `sort_inp` is held stable before `sort_out` is sampled; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `bit_in` input 1: serial frame data, first bit maps to frame bit 0.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `bit_ready` output 1: block accepts a bit this cycle.
- `sort_inp` output WIDTH: registered frame driven to the sorter `inp`.
- `sort_out` input WIDTH: sorter `out`, combinational function of `sort_inp`.
- `res_data` output WIDTH: captured sorter result.
- `res_err` output 1: captured result differs from the expected thermometer code.
- `res_valid` output 1: `res_data`/`res_err` valid.
- `res_ready` input 1: downstream accepts the result.
- `err_count` output 8: number of frames with `res_err`=1, saturating at 255.

## Operation
- States: COLLECT, SETTLE, HOLD. Reset state is COLLECT.
- `bit_ready` = (state==COLLECT). It is combinational from state, so it is 1 during and immediately after reset.
- COLLECT:
  - On each edge with `bit_valid`&&`bit_ready`, shift `bit_in` into the internal shift register at position `bit_idx`, then increment `bit_idx` (3 bits).
  - On the edge accepting the 8th bit (`bit_idx`==7):
    - load the full frame into `sort_inp`;
    - clear `bit_idx` to 0;
    - load `settle_cnt` = `SETTLE_CYCLES`-1;
    - go to SETTLE.
- `sort_inp` changes only on that 8th-bit edge. Between frames it holds the previous frame.
- SETTLE:
  - Each edge decrements `settle_cnt`.
  - On the edge where `settle_cnt`==0:
    - capture `sort_out` into `res_data`;
    - set `res_err` = (`sort_out` != expected), where expected[i] = (i < popcount(`sort_inp`));
    - set `res_valid` = 1;
    - increment `err_count` if `res_err`, saturating at 255;
    - go to HOLD.
- HOLD:
  - `res_data`, `res_err` and `res_valid` are held stable.
  - On the edge with `res_ready`=1: clear `res_valid`, go to COLLECT.
  - No bits are accepted in HOLD or SETTLE. `bit_valid` asserted in those states is ignored and not buffered.
- Arithmetic:
  - popcount is 4 bits wide, range 0..8.
  - Expected result for popcount 0 is 0x00; for popcount 8 it is 0xFF.
- Reset:
  - Reset mid-frame discards partial bits.
  - All of the following are cleared to 0: `bit_idx`, the shift register, `sort_inp`, `res_data`, `res_err`, `res_valid`, `err_count`, `settle_cnt`.

## Timing
- Reset values: `sort_inp`=0, `res_data`=0, `res_err`=0, `res_valid`=0, `err_count`=0, `bit_ready`=1.
- Latency: with the 8th bit accepted at edge E, `res_valid` rises after edge E+`SETTLE_CYCLES`. Default: 2 cycles.
- Frame throughput is at most one frame per 8+`SETTLE_CYCLES`+1 cycles when `res_ready` is tied high.
- Handshake: a result transfers on any edge with `res_valid`&&`res_ready`. `bit_ready` rises the cycle after the transfer.
- `res_ready` high while `res_valid` is low has no effect.
- Gaps in `bit_valid` during COLLECT stretch collection; partial state is retained indefinitely.

## Structure
- Package `sorter_pkg`: `WIDTH` constant (8), state enum (COLLECT, SETTLE, HOLD), and functions `popcount(WIDTH)` and `thermometer(count)` returning the expected sorted vector.
- Sub-module `sorter_result_check`: purely combinational. Computes expected from `sort_inp` and compares it to `sort_out`, producing the mismatch bit. Reused by the sorter's own bench.
- The sorter itself is instantiated at the level above, not inside this block.

## Test plan
- Reset then idle: `rst` pulse, no bits -> all outputs 0 except `bit_ready`=1; `sort_inp` stays 0x00.
- Correct sort: serial bits 0,1,0,0,1,1,0,1 with a behavioural ideal sorter model driving `sort_out` -> `sort_inp`=0xB2, `res_valid` after edge E+2, `res_data`=0x0F, `res_err`=0, `err_count`=0.
- Faulty sort: frame 0xFF with `sort_out` forced to 0x7F -> `res_err`=1, `err_count`=1. Next frame 0x00 with `sort_out`=0x00 -> `res_err`=0, `err_count` stays 1.
- Backpressure: `res_ready`=0 for 20 cycles while `bit_valid`=1 -> `bit_ready`=0, `res_data` stable, no bits consumed. Raising `res_ready` -> `res_valid` drops next edge and collection of the next frame starts.
- Reset mid-operation: assert `rst` after 5 bits, then send a full frame 0x01 -> `sort_inp`=0x01 with no leftover bits; expected result 0x01.
- Saturation/param: 256 forced-error frames -> `err_count`=255. With `SETTLE_CYCLES`=1 -> `res_valid` one edge after the 8th bit.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the perceptron sorter front/back-end.
package sorter_pkg;

    localparam int unsigned WIDTH = 8;

    typedef enum logic [1:0] {
        StCollect,
        StSettle,
        StHold
    } state_e;

    // Number of set bits in a frame, 0..8.
    function automatic logic [3:0] popcount(input logic [WIDTH-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

    // Ideal sorted result: the lowest 'count' bits set.
    function automatic logic [WIDTH-1:0] thermometer(input logic [3:0] count);
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = (4'(i) < count);
        end
        return t;
    endfunction

endpackage

// File: rtl/sorter_result_check.sv
// Combinational checker: flags a sorter output that is not the ideal thermometer code.
module sorter_result_check
    import sorter_pkg::*;
(
    input  logic [WIDTH-1:0] sort_inp,
    input  logic [WIDTH-1:0] sort_out,
    output logic             mismatch
);

    logic [WIDTH-1:0] expected;

    // Expected vector from the popcount of the frame under test.
    always_comb begin
        expected = thermometer(popcount(sort_inp));
        mismatch = (sort_out != expected);
    end

endmodule

// File: rtl/sorter_frame_loader.sv
// Assembles serial bits into frames for the sorter, samples its output after a
// settle time and offers the checked result on a valid/ready handshake.
module sorter_frame_loader #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] sort_inp,
    input  logic [WIDTH-1:0] sort_out,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       err_count
);

    import sorter_pkg::*;

    state_e           state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] sort_inp_q, sort_inp_d;
    logic [3:0]       settle_q, settle_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             mismatch;

    sorter_result_check u_check (
        .sort_inp (sort_inp_q),
        .sort_out (sort_out),
        .mismatch (mismatch)
    );

    // Next-state logic for collection, settle countdown and result hold.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        sort_inp_d  = sort_inp_q;
        settle_d    = settle_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        err_count_d = err_count_q;
        unique case (state_q)
            StCollect: begin
                if (bit_valid) begin
                    shift_d[bit_idx_q] = bit_in;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        // shift_d already holds the 8th bit here
                        sort_inp_d = shift_d;
                        bit_idx_d  = 3'd0;
                        settle_d   = 4'(SETTLE_CYCLES - 1);
                        state_d    = StSettle;
                    end
                end
            end
            StSettle: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd0) begin
                    settle_d    = 4'd0;
                    res_data_d  = sort_out;
                    res_err_d   = mismatch;
                    res_valid_d = 1'b1;
                    if (mismatch && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    state_d = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StCollect;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            sort_inp_q  <= '0;
            settle_q    <= 4'd0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sort_inp_q  <= sort_inp_d;
            settle_q    <= settle_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            err_count_q <= err_count_d;
        end
    end

    assign bit_ready = (state_q == StCollect);
    assign sort_inp  = sort_inp_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign res_valid = res_valid_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_sorter_frame_loader.sv
// Directed bench for sorter_frame_loader (default settle plus a SETTLE_CYCLES=1 copy).
module tb_sorter_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       res_ready;
    logic       force_en;
    logic [7:0] force_val;

    logic       bit_ready, bit_ready2;
    logic [7:0] sort_inp, sort_inp2;
    logic [7:0] sort_out, sort_out2;
    logic [7:0] res_data, res_data2;
    logic       res_err, res_err2;
    logic       res_valid, res_valid2;
    logic [7:0] err_count, err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ideal sorter.
    function automatic logic [7:0] model_sort(input logic [7:0] v);
        int n;
        logic [7:0] r;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        for (int i = 0; i < 8; i++) r[i] = (i < n);
        return r;
    endfunction

    assign sort_out  = force_en ? force_val : model_sort(sort_inp);
    assign sort_out2 = model_sort(sort_inp2);

    sorter_frame_loader #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sort_inp  (sort_inp),
        .sort_out  (sort_out),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_count (err_count)
    );

    sorter_frame_loader #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready2),
        .sort_inp  (sort_inp2),
        .sort_out  (sort_out2),
        .res_data  (res_data2),
        .res_err   (res_err2),
        .res_valid (res_valid2),
        .res_ready (res_ready),
        .err_count (err_count2)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for COLLECT, then sends 8 back-to-back bits; returns
    // at the negedge after the accepting edge of the 8th bit.
    task automatic send_frame(input logic [7:0] f);
        int n;
        n = 0;
        @(negedge clk);
        while (!bit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bit_ready) check("bit_ready_timeout", 32'(bit_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bit_in    = f[i];
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        check("hs_valid_drop", 32'(res_valid), 32'd0);
        check("hs_bit_ready", 32'(bit_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    task automatic wait_collect();
        int n;
        n = 0;
        while (!bit_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("collect_wait", 32'(bit_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        res_ready = 1'b0;
        force_en  = 1'b0;
        force_val = 8'h00;

        // Reset then idle
        repeat (2) @(negedge clk);
        check("rst_bit_ready", 32'(bit_ready), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_sort_inp", 32'(sort_inp), 32'h00);
        check("idle_res_data", 32'(res_data), 32'h00);
        check("idle_res_err", 32'(res_err), 32'd0);
        check("idle_res_valid", 32'(res_valid), 32'd0);
        check("idle_err_count", 32'(err_count), 32'd0);
        check("idle_bit_ready", 32'(bit_ready), 32'd1);

        // Correct sort: bits 0,1,0,0,1,1,0,1 -> 0xB2, popcount 4 -> 0x0F
        send_frame(8'hB2);
        check("cs_sort_inp", 32'(sort_inp), 32'hB2);
        check("cs_valid_e0", 32'(res_valid), 32'd0);
        check("cs_bit_ready_e0", 32'(bit_ready), 32'd0);
        @(negedge clk);
        check("cs_valid_e1", 32'(res_valid), 32'd0);
        check("s1_valid_e1", 32'(res_valid2), 32'd1);
        check("s1_res_data", 32'(res_data2), 32'h0F);
        @(negedge clk);
        check("cs_valid_e2", 32'(res_valid), 32'd1);
        check("cs_res_data", 32'(res_data), 32'h0F);
        check("cs_res_err", 32'(res_err), 32'd0);
        check("cs_err_count", 32'(err_count), 32'd0);

        // Backpressure with bits offered
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (20) @(negedge clk);
        check("bp_bit_ready", 32'(bit_ready), 32'd0);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        check("bp_res_data", 32'(res_data), 32'h0F);
        check("bp_sort_inp", 32'(sort_inp), 32'hB2);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        handshake();

        // Faulty sort then a clean empty frame
        force_en  = 1'b1;
        force_val = 8'h7F;
        send_frame(8'hFF);
        wait_valid();
        check("fs_res_data", 32'(res_data), 32'h7F);
        check("fs_res_err", 32'(res_err), 32'd1);
        check("fs_err_count", 32'(err_count), 32'd1);
        handshake();
        force_val = 8'h00;
        send_frame(8'h00);
        wait_valid();
        check("z_res_data", 32'(res_data), 32'h00);
        check("z_res_err", 32'(res_err), 32'd0);
        check("z_err_count", 32'(err_count), 32'd1);
        handshake();

        // Reset after 5 bits, then a full frame 0x01
        force_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check("mr_bit_ready", 32'(bit_ready), 32'd1);
        check("mr_err_count", 32'(err_count), 32'd0);
        send_frame(8'h01);
        check("mr_sort_inp", 32'(sort_inp), 32'h01);
        wait_valid();
        check("mr_res_data", 32'(res_data), 32'h01);
        check("mr_res_err", 32'(res_err), 32'd0);
        handshake();

        // Saturation of err_count
        force_en  = 1'b1;
        force_val = 8'h00;
        res_ready = 1'b1;
        for (int k = 0; k < 255; k++) send_frame(8'hFF);
        wait_collect();
        check("sat_255", 32'(err_count), 32'd255);
        send_frame(8'hFF);
        wait_collect();
        check("sat_hold", 32'(err_count), 32'd255);
        check("sat_last_err", 32'(res_err), 32'd1);
        res_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
